// File: rtl/priority_resolver.sv
// 8259-style priority resolver: picks the highest-ranked unmasked
// request not blocked by in-service lines, registered one-hot output.
module priority_resolver (
    input  logic       clk,
    input  logic       reset,
    input  logic       INTA,
    input  logic [7:0] IRQ_status,
    input  logic [7:0] IS_status,
    input  logic [7:0] IR_mask,
    input  logic       Rotating_priority,
    input  logic [7:0] last_serviced,
    output logic [7:0] Priority
);

    logic [7:0] priority_q;
    logic [7:0] priority_d;
    logic [7:0] cand;
    logic [7:0] cand_rot;
    logic [7:0] is_rot;
    logic [7:0] win_rot;
    logic [7:0] upto_win;
    logic [7:0] res_rot;
    logic [2:0] ls_idx;
    logic       ls_onehot;
    logic [2:0] base;
    logic       blocked;

    function automatic logic [7:0] rot_r(input logic [7:0] v,
                                         input logic [2:0] s);
        rot_r = (v >> s) | (v << (4'd8 - {1'b0, s}));
    endfunction

    function automatic logic [7:0] rot_l(input logic [7:0] v,
                                         input logic [2:0] s);
        rot_l = (v << s) | (v >> (4'd8 - {1'b0, s}));
    endfunction

    // Decode last_serviced; non-one-hot values fall back to IR0 highest
    always_comb begin
        ls_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (last_serviced[i]) ls_idx = 3'(i);
        end
        ls_onehot = (last_serviced != 8'h00) &&
                    ((last_serviced & (last_serviced - 8'd1)) == 8'h00);
        base = (Rotating_priority && ls_onehot) ? ls_idx + 3'd1 : 3'd0;
    end

    // Rotate highest rank to bit 0, encode, block, rotate back
    always_comb begin
        cand     = IRQ_status & ~IR_mask;
        cand_rot = rot_r(cand, base);
        is_rot   = rot_r(IS_status, base);
        win_rot  = cand_rot & (~cand_rot + 8'd1);
        upto_win = win_rot | (win_rot - 8'd1);
        blocked  = |(is_rot & upto_win);
        res_rot  = blocked ? 8'h00 : win_rot;
        priority_d = INTA ? priority_q : rot_l(res_rot, base);
    end

    // Output register; holds through acknowledge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) priority_q <= 8'h00;
        else       priority_q <= priority_d;
    end

    assign Priority = priority_q;

endmodule

// File: tb/tb_priority_resolver.sv
// Self-checking bench for priority_resolver: directed cases plus
// randomized traffic against a rank-order reference model.
module tb_priority_resolver;

    logic       clk = 1'b0;
    logic       reset;
    logic       INTA;
    logic [7:0] IRQ_status;
    logic [7:0] IS_status;
    logic [7:0] IR_mask;
    logic       Rotating_priority;
    logic [7:0] last_serviced;
    logic [7:0] Priority;

    int n_pass = 0;
    int n_total = 0;

    priority_resolver dut (
        .clk               (clk),
        .reset             (reset),
        .INTA              (INTA),
        .IRQ_status        (IRQ_status),
        .IS_status         (IS_status),
        .IR_mask           (IR_mask),
        .Rotating_priority (Rotating_priority),
        .last_serviced     (last_serviced),
        .Priority          (Priority)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [7:0] got,
                         input logic [7:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    endtask

    // Walk the ranking from highest to lowest line
    function automatic logic [7:0] ref_prio(input logic [7:0] irq,
                                            input logic [7:0] is,
                                            input logic [7:0] mask,
                                            input logic       rot,
                                            input logic [7:0] ls);
        int cnt = 0;
        int k = 0;
        int start = 0;
        int line;
        logic [7:0] c;
        for (int i = 0; i < 8; i++) if (ls[i]) begin cnt++; k = i; end
        if (rot && cnt == 1) start = (k + 1) % 8;
        c = irq & ~mask;
        for (int r = 0; r < 8; r++) begin
            line = (start + r) % 8;
            if (is[line]) return 8'h00;
            if (c[line]) return 8'h01 << line;
        end
        return 8'h00;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input string tag,
                         input logic [7:0] irq,
                         input logic [7:0] is,
                         input logic [7:0] mask,
                         input logic       rot,
                         input logic [7:0] ls,
                         input logic       inta,
                         input logic [7:0] exp);
        @(negedge clk);
        IRQ_status = irq;
        IS_status = is;
        IR_mask = mask;
        Rotating_priority = rot;
        last_serviced = ls;
        INTA = inta;
        step();
        check(tag, Priority, exp);
    endtask

    initial begin
        logic [7:0] exp_q;
        logic [7:0] nxt;
        logic [7:0] irq, is, mask, ls;
        logic       rot, inta;

        reset = 1'b1;
        INTA = 1'b0;
        IRQ_status = 8'hFF;
        IS_status = 8'h00;
        IR_mask = 8'h00;
        Rotating_priority = 1'b0;
        last_serviced = 8'h00;
        #1;
        check("reset_async", Priority, 8'h00);
        step();
        check("reset_hold", Priority, 8'h00);
        @(negedge clk);
        reset = 1'b0;

        apply("nest_ir1", 8'h02, 8'h00, 8'h00, 0, 8'h00, 0, 8'h02);
        apply("nest_eq_blk", 8'h02, 8'h02, 8'h00, 0, 8'h00, 0, 8'h00);
        apply("nest_preempt", 8'h01, 8'h02, 8'h00, 0, 8'h00, 0, 8'h01);
        apply("nest_ir0_blk", 8'h01, 8'h01, 8'h00, 0, 8'h00, 0, 8'h00);
        apply("rot_ls0", 8'hC0, 8'h00, 8'h00, 1, 8'h01, 0, 8'h40);
        apply("rot_is_blk", 8'hC0, 8'h40, 8'h00, 1, 8'h01, 0, 8'h00);
        apply("rot_ls6", 8'hC0, 8'h00, 8'h00, 1, 8'h40, 0, 8'h80);
        apply("rot_low_is", 8'h81, 8'h40, 8'h00, 1, 8'h40, 0, 8'h80);
        apply("mask_one", 8'h06, 8'h00, 8'h02, 0, 8'h00, 0, 8'h04);
        apply("mask_all", 8'h06, 8'h00, 8'h06, 0, 8'h00, 0, 8'h00);
        apply("rot_ls_zero", 8'h81, 8'h00, 8'h00, 1, 8'h00, 0, 8'h01);
        apply("rot_ls_multi", 8'h81, 8'h00, 8'h00, 1, 8'h11, 0, 8'h01);
        apply("mask_is_blk", 8'h04, 8'h02, 8'h02, 0, 8'h00, 0, 8'h00);
        apply("inta_pre", 8'h04, 8'h00, 8'h00, 0, 8'h00, 0, 8'h04);
        apply("inta_hold1", 8'h01, 8'h00, 8'h00, 0, 8'h00, 1, 8'h04);
        apply("inta_hold2", 8'h01, 8'h00, 8'h00, 0, 8'h00, 1, 8'h04);
        apply("inta_rel", 8'h01, 8'h00, 8'h00, 0, 8'h00, 0, 8'h01);

        #3;
        reset = 1'b1;
        #1;
        check("reset_mid", Priority, 8'h00);
        INTA = 1'b1;
        step();
        check("reset_over_inta", Priority, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        INTA = 1'b0;
        #1;
        check("reset_rel_noedge", Priority, 8'h00);
        step();
        check("reset_first_edge", Priority, 8'h01);
        exp_q = 8'h01;

        for (int n = 0; n < 400; n++) begin
            irq = 8'($urandom);
            is = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 1) == 1) is = is & 8'($urandom);
            mask = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom);
            rot = 1'($urandom);
            if ($urandom_range(0, 3) == 0) ls = 8'($urandom);
            else ls = 8'h01 << $urandom_range(0, 7);
            inta = ($urandom_range(0, 5) == 0);
            nxt = inta ? exp_q : ref_prio(irq, is, mask, rot, ls);
            apply("random", irq, is, mask, rot, ls, inta, nxt);
            exp_q = nxt;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
